vram_scanout: RTL
=================

Name: vram_scanout

Overview:
- Read-side counterpart of the layer drawing engine. The drawing engine writes sprite pixels into VRAM; this block reads VRAM in raster order and produces the VGA pixel stream (RGB plus sync).
- It generates the display timing and the VRAM read addresses, and integer-upscales the framebuffer to the visible area.
- It tells the drawing side when vertical blanking starts and ends, so layer redraws can be confined to blanking.

Parameters:
- FB_WIDTH, 160: framebuffer width in pixels (VRAM row stride).
- FB_HEIGHT, 120: framebuffer height in pixels.
- SCALE, 4: integer upscale factor in both axes (power of two not required).
- VRAM_A_WIDTH, 16: VRAM address width.
- PIX_W, 12: pixel width (RGB444).
- H_VIS, 640: horizontal visible ticks.
- H_FP, 16: horizontal front porch ticks.
- H_SYNC, 96: horizontal sync ticks.
- H_BP, 48: horizontal back porch ticks.
- V_VIS, 480: vertical visible lines.
- V_FP, 10: vertical front porch lines.
- V_SYNC, 2: vertical sync lines.
- V_BP, 33: vertical back porch lines.

Ports:
- CLK  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  pixel tick enable; all state advances only when ena=1.
- vram_data  in  PIX_W  VRAM read data; synchronous RAM, 1 CLK read latency, output held while address is stable.
- vram_addr  out  VRAM_A_WIDTH  registered VRAM read address.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- rgb  out  PIX_W  pixel colour; 0 outside the framebuffer window.
- o_vblank  out  1  high while the vertical counter is at or beyond V_VIS (stage-0 timing).
- o_frame_start  out  1  one-CLK pulse on the ena tick where the vertical counter enters V_VIS (blanking begins).

Behaviour:
- Reset (async, rst_n=0): h_cnt=0, v_cnt=0, all sub-counters=0, row_base=0.
  - Outputs: vram_addr=0, hsync=1, vsync=1, rgb=0, o_vblank=0, o_frame_start=0.
  - Reset is allowed mid-frame; the block restarts at (0,0) on the next ena after release.
- Stage 0 (counters), per ena tick:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (default 800), then wraps to 0.
  - On h_cnt wrap, v_cnt increments; it runs 0..V_TOTAL-1 (default 525), then wraps to 0.
- Address generation is incremental; no multiplier on the address path:
  - x_sub counts 0..SCALE-1 inside the window. On wrap, fb_x increments.
  - At line end, fb_x and x_sub clear. y_sub counts 0..SCALE-1; on wrap, row_base += FB_WIDTH.
  - At frame wrap, row_base, y_sub, fb_x and x_sub all clear.
  - Window condition: h_cnt < FB_WIDTH*SCALE and v_cnt < FB_HEIGHT*SCALE.
- Stage 1 (registered on the same ena tick from stage-0 values):
  - vram_addr <= row_base+fb_x when in window; otherwise vram_addr holds its last value (no out-of-range reads).
  - win1 <= window condition.
  - hs1 <= !(H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC).
  - vs1 <= !(V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC).
- Stage 2 (next ena tick): rgb <= win1 ? vram_data : 0; hsync <= hs1; vsync <= vs1.
- Latency:
  - rgb, hsync and vsync lag the counters by exactly 2 ena ticks, and are mutually aligned.
  - vram_addr lags the counters by 1 tick.
- ena=0 for any number of cycles: everything freezes, outputs hold, and o_frame_start stays 0.
  - The 1-CLK RAM latency is always satisfied, because RAM data is sampled no earlier than the next ena.
- o_vblank is registered and goes 1 on the tick where v_cnt becomes V_VIS. It goes 0 on the tick where v_cnt wraps to 0.
- o_frame_start is 1 for exactly one CLK, coinciding with the rising edge of o_vblank.
- Width rules:
  - h_cnt and v_cnt are 10 bits.
  - vram_addr is truncated to VRAM_A_WIDTH; FB_WIDTH*FB_HEIGHT must be ≤ 2^VRAM_A_WIDTH.
  - row_base never exceeds (FB_HEIGHT-1)*FB_WIDTH.
- Framebuffer smaller than the visible area (FB_WIDTH*SCALE < H_VIS or FB_HEIGHT*SCALE < V_VIS): the image sits top-left and the remainder is black.

Test Plan:
- Reset then ena=1 continuous, defaults:
  - vram_addr sequence on line 0 is 0×4, 1×4, …, 159×4.
  - Lines 4..7 start at 160.
  - Line 476 starts at 119*160=19040.
- Timing:
  - hsync low for exactly 96 ticks, first low sample 2 ticks after h_cnt=656.
  - vsync low for exactly 2 lines (1600 ticks) starting at line 490.
  - Frame period is 420000 ticks.
- Model VRAM with data=address[11:0]:
  - rgb at output tick h=2 of line 0 equals 0.
  - rgb equals 0 throughout h≥640 and v≥480.
  - Check alignment: no one-pixel shift at the window edge.
- ena pulsed every 4th CLK: all output waveforms are identical per tick to the continuous case; outputs are stable between ticks.
- o_frame_start: exactly one 1-CLK pulse per frame, simultaneous with o_vblank rising at v=480; o_vblank falls at v=0.
- rst_n asserted asynchronously mid-line (h=300, v=200):
  - Outputs go to reset values immediately, without waiting for CLK.
  - After release, the first vram_addr is 0 and the sequence restarts cleanly.
- FB_WIDTH=100, FB_HEIGHT=50, SCALE=2 (small-window case):
  - Address max is 4999.
  - rgb=0 for h≥200 or v≥100.
  - vram_addr holds at its last value outside the window.

Source files
------------

// File: rtl/vram_scanout.sv
`timescale 1ns/1ps
// vram_scanout: reads VRAM in raster order and produces an upscaled VGA
// pixel stream (RGB + active-low syncs), plus vertical-blank indications
// for the drawing side. Three-stage pipeline on the ena tick:
//   stage 0 = counters, stage 1 = address/window/sync, stage 2 = pixel out.
module vram_scanout #(
  parameter int FB_WIDTH     = 160,
  parameter int FB_HEIGHT    = 120,
  parameter int SCALE        = 4,
  parameter int VRAM_A_WIDTH = 16,
  parameter int PIX_W        = 12,
  parameter int H_VIS        = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VIS        = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [PIX_W-1:0]        vram_data,
  output logic [VRAM_A_WIDTH-1:0] vram_addr,
  output logic                    hsync,
  output logic                    vsync,
  output logic [PIX_W-1:0]        rgb,
  output logic                    o_vblank,
  output logic                    o_frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int XS_W    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int FBX_W   = $clog2(FB_WIDTH + 1);

  localparam logic [9:0] H_LAST_C   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_C   = 10'(V_TOTAL - 1);
  localparam logic [9:0] WIN_W_C    = 10'(FB_WIDTH * SCALE);
  localparam logic [9:0] WIN_H_C    = 10'(FB_HEIGHT * SCALE);
  localparam logic [9:0] HS_START_C = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END_C   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START_C = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END_C   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] V_VIS_C    = 10'(V_VIS);

  localparam logic [XS_W-1:0]         SUB_LAST_C = XS_W'(SCALE - 1);
  localparam logic [VRAM_A_WIDTH-1:0] ROW_STEP_C = VRAM_A_WIDTH'(FB_WIDTH);
  localparam logic [VRAM_A_WIDTH-1:0] ROW_LAST_C = VRAM_A_WIDTH'((FB_HEIGHT - 1) * FB_WIDTH);

  // Stage 0 state
  logic [9:0]              r_h_cnt;
  logic [9:0]              r_v_cnt;
  logic [XS_W-1:0]         r_x_sub;
  logic [XS_W-1:0]         r_y_sub;
  logic [FBX_W-1:0]        r_fb_x;
  logic [VRAM_A_WIDTH-1:0] r_row_base;
  logic                    r_vblank;
  logic                    r_frame_start;

  // Stage 1 state
  logic [VRAM_A_WIDTH-1:0] r_vram_addr;
  logic                    r_win1;
  logic                    r_hs1;
  logic                    r_vs1;

  // Stage 2 state
  logic [PIX_W-1:0]        r_rgb;
  logic                    r_hsync;
  logic                    r_vsync;

  // Combinational helpers derived from stage-0 values
  logic                    w_h_last;
  logic                    w_v_last;
  logic [9:0]              w_h_next;
  logic [9:0]              w_v_next;
  logic                    w_in_h;
  logic                    w_in_v;
  logic                    w_win;
  logic                    w_x_last;
  logic                    w_y_last;
  logic                    w_row_last;
  logic [VRAM_A_WIDTH-1:0] w_addr;
  logic                    w_hs_act;
  logic                    w_vs_act;
  logic                    w_enter_vblank;

  assign w_h_last   = (r_h_cnt == H_LAST_C);
  assign w_v_last   = (r_v_cnt == V_LAST_C);
  assign w_h_next   = w_h_last ? 10'd0 : r_h_cnt + 10'd1;
  assign w_v_next   = w_h_last ? (w_v_last ? 10'd0 : r_v_cnt + 10'd1) : r_v_cnt;
  assign w_in_h     = (r_h_cnt < WIN_W_C);
  assign w_in_v     = (r_v_cnt < WIN_H_C);
  assign w_win      = w_in_h && w_in_v;
  assign w_x_last   = (r_x_sub == SUB_LAST_C);
  assign w_y_last   = (r_y_sub == SUB_LAST_C);
  assign w_row_last = (r_row_base == ROW_LAST_C);
  // Incremental address: row base plus column, no multiplier on this path.
  assign w_addr     = r_row_base + VRAM_A_WIDTH'(r_fb_x);
  assign w_hs_act   = (r_h_cnt >= HS_START_C) && (r_h_cnt < HS_END_C);
  assign w_vs_act   = (r_v_cnt >= VS_START_C) && (r_v_cnt < VS_END_C);
  // Blanking begins on the tick that moves the line counter onto V_VIS.
  assign w_enter_vblank = (w_v_next == V_VIS_C) && (r_v_cnt != V_VIS_C);

  // Stage 0: raster counters and the upscaling sub-counters / row base.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_x_sub    <= '0;
      r_y_sub    <= '0;
      r_fb_x     <= '0;
      r_row_base <= '0;
    end else if (ena) begin
      r_h_cnt <= w_h_next;
      r_v_cnt <= w_v_next;
      if (w_h_last) begin
        r_x_sub <= '0;
        r_fb_x  <= '0;
        if (w_v_last) begin
          r_y_sub    <= '0;
          r_row_base <= '0;
        end else if (w_in_v) begin
          if (w_y_last) begin
            r_y_sub    <= '0;
            // After the last framebuffer row, park at 0 rather than run past the image.
            r_row_base <= w_row_last ? '0 : r_row_base + ROW_STEP_C;
          end else begin
            r_y_sub <= r_y_sub + XS_W'(1);
          end
        end
      end else if (w_win) begin
        if (w_x_last) begin
          r_x_sub <= '0;
          r_fb_x  <= r_fb_x + FBX_W'(1);
        end else begin
          r_x_sub <= r_x_sub + XS_W'(1);
        end
      end
    end
  end

  // Vertical-blank flag tracks the stage-0 line counter; start pulse lasts one CLK.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_vblank      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= ena && w_enter_vblank;
      if (ena) begin
        r_vblank <= (w_v_next >= V_VIS_C);
      end
    end
  end

  // Stage 1: VRAM address (held outside the window), window flag and raw syncs.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_vram_addr <= '0;
      r_win1      <= 1'b0;
      r_hs1       <= 1'b1;
      r_vs1       <= 1'b1;
    end else if (ena) begin
      if (w_win) begin
        r_vram_addr <= w_addr;
      end
      r_win1 <= w_win;
      r_hs1  <= !w_hs_act;
      r_vs1  <= !w_vs_act;
    end
  end

  // Stage 2: pixel output aligned with the delayed syncs; black outside the window.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (ena) begin
      r_rgb   <= r_win1 ? vram_data : '0;
      r_hsync <= r_hs1;
      r_vsync <= r_vs1;
    end
  end

  assign vram_addr     = r_vram_addr;
  assign hsync         = r_hsync;
  assign vsync         = r_vsync;
  assign rgb           = r_rgb;
  assign o_vblank      = r_vblank;
  assign o_frame_start = r_frame_start;

endmodule
